// File: rtl/crc_ccitt_arbiter.sv
// Two-requester round-robin arbiter feeding a bit-serial CRC-16 engine, one frame per grant.
// Optional feature: define CRC_INIT_ONES_EN for an all-ones per-frame init (CCITT-FALSE); default init is zero (XMODEM).
module crc_ccitt_arbiter #(
  parameter logic [15:0] POLY = 16'h1021
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic        crc_valid,
  output logic [15:0] crc_out,
  output logic        crc_id,
  output logic        busy
);

  localparam int unsigned CRC_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

`ifdef CRC_INIT_ONES_EN
  localparam logic [CRC_W-1:0] INIT = 16'hFFFF;
`else
  localparam logic [CRC_W-1:0] INIT = 16'h0000;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t             state;
  logic               grant;
  logic               last_grant;
  logic [CRC_W-1:0]   crc;
  logic [BYTE_W-1:0]  shreg;
  logic               last_flag;
  logic [CNT_W-1:0]   bit_cnt;
  logic               fb;
  logic [CRC_W-1:0]   crc_next;
  logic [BYTE_W-1:0]  granted_data;

  // MSB-first serial CRC step
  assign fb           = crc[CRC_W-1] ^ shreg[BYTE_W-1];
  assign crc_next     = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : CRC_W'(0));
  assign granted_data = grant ? req_data[15:8] : req_data[7:0];

  // Only the granted requester sees ready, and only while a byte is awaited
  always_comb begin
    req_ready = 2'b00;
    if (state == LOAD) req_ready[grant] = req_valid[grant];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      crc        <= CRC_W'(0);
      shreg      <= BYTE_W'(0);
      last_flag  <= 1'b0;
      bit_cnt    <= CNT_W'(0);
      crc_valid  <= 1'b0;
      crc_out    <= CRC_W'(0);
      crc_id     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            // tie goes to whoever was not served last
            grant <= (req_valid[0] && req_valid[1]) ? ~last_grant : req_valid[1];
            crc   <= INIT;
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (req_valid[grant]) begin
            shreg     <= granted_data;
            last_flag <= req_last[grant];
            bit_cnt   <= CNT_W'(0);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          crc     <= crc_next;
          shreg   <= {shreg[BYTE_W-2:0], 1'b0};
          bit_cnt <= CNT_W'(bit_cnt + CNT_W'(1));
          if (bit_cnt == CNT_W'(7)) state <= last_flag ? DONE : LOAD;
        end
        DONE: begin
          crc_valid  <= 1'b1;
          crc_out    <= crc;
          crc_id     <= grant;
          last_grant <= grant;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/crc_ccitt_arbiter.md
CRC_CCITT_ARBITER -- requirements
Module: crc_ccitt_arbiter

Interface
REQ-001 Parameter POLY, default 16'h1021, SHALL set the generator polynomial (x^16+x^12+x^5+1 by default).
REQ-002 clk  input  1  SHALL be the clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 req_valid  input  2  SHALL be the per-requester byte-valid; bit i belongs to requester i.
REQ-005 req_data  input  16  SHALL carry the requester bytes: [7:0] is requester 0, [15:8] is requester 1.
REQ-006 req_last  input  2  SHALL mark the presented byte as the final byte of the frame, per requester.
REQ-007 req_ready  output  2  SHALL be the per-requester byte-accept; a byte transfers when valid and ready are both high on a rising edge.
REQ-008 crc_valid  output  1  SHALL be a one-cycle pulse marking a completed frame CRC.
REQ-009 crc_out  output  16  SHALL hold the most recent completed CRC.
REQ-010 crc_id  output  1  SHALL hold the requester index that owns crc_out.
REQ-011 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-013 IDLE: if any req_valid is high, the FSM SHALL register a grant and go to LOAD; the CRC register SHALL load the init value (REQ-027).
REQ-014 Arbitration SHALL be round-robin per frame: the requester not granted last wins a tie; priority after reset goes to requester 0.
REQ-015 A grant SHALL be held for the whole frame until DONE; the other requester SHALL see req_ready=0 throughout.
REQ-016 LOAD: req_ready[grant] SHALL equal req_valid[grant] (combinational); on transfer, the byte and last flag SHALL be captured and the FSM SHALL go to SHIFT; without valid it SHALL stay in LOAD indefinitely.
REQ-017 SHIFT SHALL process exactly 8 bits, one per cycle, MSB first: fb=crc[15]^bit; crc={crc[14:0],0}^(fb?POLY:0).
REQ-018 After the 8th bit, the FSM SHALL go to DONE if the captured last flag is set, else to LOAD.
REQ-019 DONE SHALL last one cycle with crc_valid=1, crc_out=final CRC and crc_id=grant; it SHALL then update the last-grant pointer and return to IDLE.
REQ-020 Byte throughput SHALL be one byte per 9 cycles when valid is held high.
REQ-021 crc_valid SHALL rise exactly 9 clock edges after the transfer edge of the last byte.
REQ-022 crc_out and crc_id SHALL hold their value between DONE pulses.
REQ-023 A requester SHALL hold req_data and req_last stable while valid and not ready; the block does not sample them outside the transfer edge.
REQ-024 No zero-length frames: every frame SHALL contain at least one byte.

Reset
REQ-025 On rst, the FSM SHALL go to IDLE with req_ready=0, crc_valid=0, crc_out=16'h0000, crc_id=0, busy=0 and the last-grant pointer set so requester 0 has priority.
REQ-026 Reset mid-frame SHALL abort the frame with no crc_valid; the next frame after reset SHALL compute correctly.

Configuration
REQ-027 Macro CRC_INIT_ONES_EN: when defined, the per-frame init value SHALL be 16'hFFFF (CCITT-FALSE); when undefined, 16'h0000 (XMODEM). No output XOR and no bit reflection in either case.

Verification
REQ-028 Macro undefined, req0 sends single byte 0x01 with last -> crc_out=0x1021, crc_id=0, crc_valid 9 edges after transfer.
REQ-029 req1 sends ASCII "123456789" -> crc_out=0x31C3 with macro undefined; 0x29B1 with CRC_INIT_ONES_EN; crc_id=1.
REQ-030 Both requesters hold one-byte frames valid continuously from reset -> grant order 0,1,0,1; each result is separated by ≥10 cycles.
REQ-031 req0 sends 0x12,0x34 (macro undefined) with valid dropped 5 cycles between bytes -> CRC identical to the contiguous case; req1 (valid throughout) gets no req_ready until after req0's DONE.
REQ-032 rst pulsed during SHIFT of a req0 frame -> all outputs 0 next cycle, no crc_valid; a following req0 byte 0x00 (macro undefined) -> crc_out=0x0000, crc_valid pulses.
